// File: rtl/sccb_target.sv
// SCCB/I2C target: oversamples sioc/siod, detects START/STOP, ACKs its device address and
// turns register writes and sequential reads into accesses on an external register file.
module sccb_target #(
    parameter logic [6:0] DEVICE_ID = 7'h21
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        StIdle, StDevAddr, StDevAck, StRegAddr, StRegAck,
        StWrData, StWrAck, StRdData, StRdAck
    } state_e;

    state_e     r_state, w_state_next;
    logic       r_sioc_meta, r_sioc_sync, r_sioc_hist;
    logic       r_siod_meta, r_siod_sync, r_siod_hist;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic       r_rw;
    logic       r_siod_oe;
    logic       r_busy;
    logic       r_wr_en;
    logic [7:0] r_wr_addr, r_wr_data;

    logic       w_rise, w_fall, w_start, w_stop, w_last, w_id_match;
    logic [7:0] w_byte;
    logic       w_oe_next, w_busy_next, w_wr_stb, w_load, w_ptr_load, w_ptr_inc;

    assign w_rise     = r_sioc_sync & ~r_sioc_hist;
    assign w_fall     = ~r_sioc_sync & r_sioc_hist;
    assign w_start    = r_sioc_sync & r_sioc_hist & r_siod_hist & ~r_siod_sync;
    assign w_stop     = r_sioc_sync & r_sioc_hist & ~r_siod_hist & r_siod_sync;
    assign w_last     = (r_bit_cnt == 4'd7);
    assign w_byte     = {r_shift[6:0], r_siod_sync};
    assign w_id_match = (w_byte[7:1] == DEVICE_ID);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = StDevAddr;
        end else if (w_stop) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle:    w_state_next = StIdle;
                StDevAddr: if (w_rise && w_last) w_state_next = w_id_match ? StDevAck : StIdle;
                StDevAck:  if (w_fall && r_siod_oe) w_state_next = r_rw ? StRdData : StRegAddr;
                StRegAddr: if (w_rise && w_last) w_state_next = StRegAck;
                StRegAck:  if (w_fall && r_siod_oe) w_state_next = StWrData;
                StWrData:  if (w_rise && w_last) w_state_next = StWrAck;
                StWrAck:   if (w_fall && r_siod_oe) w_state_next = StWrData;
                StRdData:  if (w_fall && r_bit_cnt == 4'd8) w_state_next = StRdAck;
                StRdAck: begin
                    // NACK parks in idle (busy stays set) until the master issues STOP/START
                    if (w_rise && r_siod_sync) w_state_next = StIdle;
                    else if (w_fall && r_bit_cnt == 4'd1) w_state_next = StRdData;
                end
                default:   w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_oe_next   = r_siod_oe;
        w_busy_next = r_busy;
        w_wr_stb    = 1'b0;
        w_load      = 1'b0;
        w_ptr_load  = 1'b0;
        w_ptr_inc   = 1'b0;
        if (w_start || w_stop) begin
            w_oe_next   = 1'b0;
            w_busy_next = 1'b0;
        end else begin
            case (r_state)
                StIdle: w_oe_next = 1'b0;
                StDevAddr: begin
                    if (w_rise && w_last && w_id_match) w_busy_next = 1'b1;
                end
                StDevAck, StRegAck, StWrAck: begin
                    // First fall starts the ACK, the fall after the ACK clock ends it
                    if (w_fall) begin
                        w_oe_next = ~r_siod_oe;
                        if (r_siod_oe && r_state == StDevAck && r_rw) begin
                            w_load    = 1'b1;
                            w_oe_next = ~rd_data[7];
                        end
                    end
                end
                StRegAddr: begin
                    if (w_rise && w_last) w_ptr_load = 1'b1;
                end
                StWrData: begin
                    if (w_rise && w_last) begin
                        w_wr_stb  = 1'b1;
                        w_ptr_inc = 1'b1;
                    end
                end
                StRdData: begin
                    if (w_fall) w_oe_next = (r_bit_cnt == 4'd8) ? 1'b0 : ~r_shift[7];
                    if (w_rise && w_last) w_ptr_inc = 1'b1;
                end
                StRdAck: begin
                    if (w_fall && r_bit_cnt == 4'd1) begin
                        w_load    = 1'b1;
                        w_oe_next = ~rd_data[7];
                    end
                end
                default: w_oe_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_sioc_meta <= 1'b1;
            r_sioc_sync <= 1'b1;
            r_sioc_hist <= 1'b1;
            r_siod_meta <= 1'b1;
            r_siod_sync <= 1'b1;
            r_siod_hist <= 1'b1;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_ptr       <= 8'd0;
            r_rw        <= 1'b0;
            r_siod_oe   <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 8'd0;
            r_wr_data   <= 8'd0;
        end else begin
            r_sioc_meta <= sioc_in;
            r_sioc_sync <= r_sioc_meta;
            r_sioc_hist <= r_sioc_sync;
            r_siod_meta <= siod_in;
            r_siod_sync <= r_siod_meta;
            r_siod_hist <= r_siod_sync;
            r_siod_oe   <= w_oe_next;
            r_busy      <= w_busy_next;
            r_wr_en     <= w_wr_stb;
            if (w_wr_stb) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte;
            end
            if (w_ptr_load) begin
                r_ptr <= w_byte;
            end else if (w_ptr_inc) begin
                r_ptr <= r_ptr + 8'd1;
            end
            if (r_state == StDevAddr && w_rise && w_last) begin
                r_rw <= r_siod_sync;
            end
            if (w_start || r_state != w_state_next) begin
                r_bit_cnt <= 4'd0;
            end else if (w_rise) begin
                case (r_state)
                    StDevAddr, StRegAddr, StWrData: begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_shift   <= w_byte;
                    end
                    StRdData: begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_shift   <= {r_shift[6:0], 1'b0};
                    end
                    StRdAck: if (!r_siod_sync) r_bit_cnt <= 4'd1;
                    default: r_bit_cnt <= r_bit_cnt;
                endcase
            end
            if (w_load) begin
                r_shift <= rd_data;
            end
        end
    end

    assign siod_oe = r_siod_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_addr = r_ptr;
    assign busy    = r_busy;

endmodule

// File: tb/tb_sccb_target.sv
// Scoreboard bench for sccb_target: a bus master issues directed SCCB transfers while monitors
// compare register-write strobes and target-driven bus bits against queued expectations.
module tb_sccb_target;

    localparam int Q = 8;  // quarter bit period in clk_50 cycles

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic       sioc = 1'b1;
    logic       master_low = 1'b0;
    logic       siod;
    logic       siod_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic [7:0] rd_data = 8'h00;

    int         n_checks = 0;
    int         n_pass = 0;
    string      phase = "init";
    logic       tgt_slot = 1'b0;
    logic       sioc_prev = 1'b1;
    logic       oe_prev = 1'b0;
    logic [15:0] exp_wr[$];
    logic        exp_bit[$];

    assign siod = ~(master_low | siod_oe);

    always #10 clk_50 = ~clk_50;

    // Register file model: data = address ^ 0x5A, one cycle latency
    always @(posedge clk_50) rd_data <= rd_addr ^ 8'h5A;

    sccb_target #(.DEVICE_ID(7'h21)) dut (
        .clk_50  (clk_50),
        .reset   (reset),
        .sioc_in (sioc),
        .siod_in (siod),
        .siod_oe (siod_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL [%s] %s: got %h expected %h", phase, name, got, exp);
    endtask

    always @(negedge clk_50) begin
        sioc_prev <= sioc;
        oe_prev   <= siod_oe;
        if (!reset && wr_en) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                $display("FAIL [%s] unexpected wr_en: got addr %h data %h expected none",
                         phase, wr_addr, wr_data);
            end else begin
                check("wr_en addr/data", {16'h0, wr_addr, wr_data}, {16'h0, exp_wr.pop_front()});
            end
        end
        if (sioc && !sioc_prev && tgt_slot) begin
            if (exp_bit.size() == 0) begin
                n_checks++;
                $display("FAIL [%s] bus bit: got %b expected none queued", phase, siod);
            end else begin
                check("bus bit", {31'h0, siod}, {31'h0, exp_bit.pop_front()});
            end
        end
        if (siod_oe && !oe_prev && sioc && sioc_prev) begin
            n_checks++;
            $display("FAIL [%s] siod_oe rise while sioc high: got 1 expected 0", phase);
        end
    end

    task automatic qwait(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic clock_bit(input logic drive_low);
        master_low = drive_low;
        qwait(Q);
        sioc = 1'b1;
        qwait(2 * Q);
        sioc = 1'b0;
        qwait(Q);
    endtask

    task automatic bus_start;
        master_low = 1'b0;
        qwait(Q);
        sioc = 1'b1;
        qwait(Q);
        master_low = 1'b1;
        qwait(Q);
        sioc = 1'b0;
        qwait(Q);
    endtask

    task automatic bus_stop;
        master_low = 1'b1;
        qwait(Q);
        sioc = 1'b1;
        qwait(Q);
        master_low = 1'b0;
        qwait(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic acked);
        for (int i = 7; i >= 0; i--) clock_bit(~b[i]);
        exp_bit.push_back(~acked);
        tgt_slot = 1'b1;
        clock_bit(1'b0);
        tgt_slot = 1'b0;
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic master_ack);
        for (int i = 7; i >= 0; i--) begin
            exp_bit.push_back(exp[i]);
            tgt_slot = 1'b1;
            clock_bit(1'b0);
        end
        tgt_slot = 1'b0;
        clock_bit(master_ack);
    endtask

    initial begin
        qwait(4);
        reset = 1'b0;
        qwait(2);
        phase = "reset";
        check("siod_oe", siod_oe, 0);
        check("wr_en", wr_en, 0);
        check("wr_addr", wr_addr, 0);
        check("wr_data", wr_data, 0);
        check("rd_addr", rd_addr, 0);
        check("busy", busy, 0);

        phase = "single write";
        bus_start;
        wr_byte(8'h42, 1'b1);
        check("busy after id", busy, 1);
        wr_byte(8'h12, 1'b1);
        exp_wr.push_back(16'h1280);
        wr_byte(8'h80, 1'b1);
        bus_stop;
        check("busy after stop", busy, 0);
        check("rd_addr", rd_addr, 8'h13);

        phase = "burst wrap";
        bus_start;
        wr_byte(8'h42, 1'b1);
        wr_byte(8'hFE, 1'b1);
        exp_wr.push_back(16'hFEAA);
        exp_wr.push_back(16'hFFBB);
        exp_wr.push_back(16'h00CC);
        wr_byte(8'hAA, 1'b1);
        wr_byte(8'hBB, 1'b1);
        wr_byte(8'hCC, 1'b1);
        bus_stop;
        check("rd_addr", rd_addr, 8'h01);

        phase = "read";
        bus_start;
        wr_byte(8'h42, 1'b1);
        wr_byte(8'h0A, 1'b1);
        bus_start;
        wr_byte(8'h43, 1'b1);
        rd_byte(8'h50, 1'b1);
        rd_byte(8'h51, 1'b0);
        qwait(4);
        check("siod_oe after nack", siod_oe, 0);
        check("rd_addr", rd_addr, 8'h0C);
        bus_stop;
        check("busy after stop", busy, 0);

        phase = "other device";
        bus_start;
        wr_byte(8'h60, 1'b0);
        check("busy", busy, 0);
        wr_byte(8'h12, 1'b0);
        check("siod_oe", siod_oe, 0);
        bus_stop;

        phase = "stop mid byte";
        bus_start;
        wr_byte(8'h42, 1'b1);
        wr_byte(8'h01, 1'b1);
        for (int i = 0; i < 5; i++) clock_bit(1'b1);
        bus_stop;
        check("busy", busy, 0);
        check("siod_oe", siod_oe, 0);
        bus_start;
        wr_byte(8'h42, 1'b1);
        wr_byte(8'h01, 1'b1);
        exp_wr.push_back(16'h0180);
        wr_byte(8'h80, 1'b1);
        bus_stop;
        check("rd_addr", rd_addr, 8'h02);

        phase = "reset in ack";
        bus_start;
        for (int i = 7; i >= 0; i--) clock_bit(~(8'h42 >> i) & 1'b1);
        master_low = 1'b0;
        qwait(Q);
        check("siod_oe during ack", siod_oe, 1);
        reset = 1'b1;
        qwait(1);
        reset = 1'b0;
        check("siod_oe after reset", siod_oe, 0);
        check("rd_addr after reset", rd_addr, 0);
        check("busy after reset", busy, 0);
        sioc = 1'b1;
        qwait(2 * Q);
        sioc = 1'b0;
        qwait(Q);
        bus_stop;
        bus_start;
        wr_byte(8'h42, 1'b1);
        wr_byte(8'h33, 1'b1);
        exp_wr.push_back(16'h3344);
        wr_byte(8'h44, 1'b1);
        bus_stop;
        check("rd_addr", rd_addr, 8'h34);

        phase = "end";
        qwait(8);
        check("pending writes", exp_wr.size(), 0);
        check("pending bus bits", exp_bit.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL [%s] timeout: got no finish expected finish", phase);
        $fatal(1);
    end

endmodule
